// File: rtl/gpu_cmd_pkg.sv
// Shared opcode, channel and error-code constants for the host command path.
package gpu_cmd_pkg;

    localparam int unsigned NUM_CH_DEF = 8;
    localparam int unsigned OPW_DEF    = 8;

    localparam logic [7:0] OP_NOP               = 8'd0;
    localparam logic [7:0] OP_SWAP              = 8'd1;
    localparam logic [7:0] OP_CLEAN             = 8'd2;
    localparam logic [7:0] OP_LOAD_VERTEX_BEGIN = 8'd3;
    localparam logic [7:0] OP_LOAD_VERTEX_CONT  = 8'd4;
    localparam logic [7:0] OP_LOAD_EDGE_BEGIN   = 8'd5;
    localparam logic [7:0] OP_LOAD_EDGE_CONT    = 8'd6;

    localparam int unsigned CH_SWAP              = 0;
    localparam int unsigned CH_CLEAN             = 1;
    localparam int unsigned CH_LOAD_VERTEX_BEGIN = 2;
    localparam int unsigned CH_LOAD_VERTEX_CONT  = 3;
    localparam int unsigned CH_LOAD_EDGE_BEGIN   = 4;
    localparam int unsigned CH_LOAD_EDGE_CONT    = 5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_STALE   = 2'd3;

    // CONTINUE channels follow their BEGIN channel directly below them.
    localparam logic [7:0] CONT_MASK_DEF = 8'b0010_1000;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO holding queued command opcodes.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OPW   = 8
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [OPW-1:0]           wdata,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [OPW-1:0]           head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [OPW-1:0] mem [DEPTH];
    logic [AW:0]    wr_cnt_q, wr_cnt_d;
    logic [AW:0]    rd_cnt_q, rd_cnt_d;
    logic           full;
    logic           do_push;
    logic           do_pop;

    // Counters carry one extra bit so full and empty stay distinguishable.
    always_comb begin
        level      = wr_cnt_q - rd_cnt_q;
        full       = (level == (AW+1)'(DEPTH));
        head_valid = (level != '0);
        push_ready = !full;
        do_push    = push_valid && !full;
        do_pop     = pop && head_valid;
        wr_cnt_d   = do_push ? wr_cnt_q + 1'b1 : wr_cnt_q;
        rd_cnt_d   = do_pop ? rd_cnt_q + 1'b1 : rd_cnt_q;
        head       = mem[rd_cnt_q[AW-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_cnt_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/cmd_dispatch.sv
// Queues host opcodes and issues each, in order, as a one-cycle strobe to its engine.
module cmd_dispatch
    import gpu_cmd_pkg::*;
#(
    parameter int unsigned        NUM_CH    = NUM_CH_DEF,
    parameter int unsigned        OPW       = OPW_DEF,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [NUM_CH-1:0]  CONT_MASK = NUM_CH'(CONT_MASK_DEF),
    parameter int unsigned        ISSUE_GAP = 1,
    parameter int unsigned        TIMEOUT   = 255
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [OPW-1:0]          opcode,
    input  logic [NUM_CH-1:0]       BUSY,
    output logic [NUM_CH-1:0]       CMD,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam int unsigned SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    if (CONT_MASK[0]) begin : g_bad_cont_mask
        $error("cmd_dispatch: channel 0 has no predecessor and cannot be a CONTINUE channel");
    end

    logic              head_valid;
    logic [OPW-1:0]    head_op;
    logic              pop;
    logic [NUM_CH-1:0] elig_vec;

    logic [OPW-1:0]    ch_raw;
    logic [CW-1:0]     head_ch;
    logic              head_legal;
    logic              head_cont;
    logic              head_elig;
    logic              stalled;
    logic              do_issue;
    logic              do_illegal;
    logic              do_timeout;

    logic [GW-1:0]     gap_q, gap_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic [NUM_CH-1:0] cmd_q, cmd_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .OPW   (OPW)
    ) u_fifo (
        .CLK        (CLK),
        .rst        (rst),
        .push_valid (pkt_valid),
        .push_ready (pkt_ready),
        .wdata      (opcode),
        .pop        (pop),
        .head_valid (head_valid),
        .head       (head_op),
        .level      (level)
    );

    // A CONTINUE channel may only go while its BEGIN engine still holds the session.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
        if (i == 0) begin : g_first
            assign elig_vec[i] = CONT_MASK[i] ? 1'b0 : !BUSY[i];
        end else begin : g_rest
            assign elig_vec[i] = CONT_MASK[i] ? BUSY[i-1] : !BUSY[i];
        end
    end

    always_comb begin
        ch_raw     = head_op - OPW'(1);
        head_ch    = ch_raw[CW-1:0];
        head_legal = (head_op != '0) && (head_op <= OPW'(NUM_CH));
        head_cont  = head_legal && CONT_MASK[head_ch];
        head_elig  = head_legal && elig_vec[head_ch];
        stalled    = head_valid && head_legal && !head_elig;

        do_issue   = head_valid && head_elig && (gap_q == '0);
        do_illegal = head_valid && !head_legal;
        do_timeout = stalled && (TIMEOUT != 0) && (stall_q == SW'(TIMEOUT - 1));
        pop        = do_issue || do_illegal || do_timeout;

        stall_d = stall_q;
        if (pop) begin
            stall_d = '0;
        end else if (stalled && (TIMEOUT != 0)) begin
            stall_d = stall_q + 1'b1;
        end

        gap_d = gap_q;
        if (do_issue) begin
            gap_d = GW'(ISSUE_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        cmd_d = '0;
        if (do_issue) begin
            cmd_d[head_ch] = 1'b1;
        end

        err_d      = do_illegal || do_timeout;
        err_code_d = err_code_q;
        if (do_illegal) begin
            err_code_d = ERR_ILLEGAL;
        end else if (do_timeout) begin
            err_code_d = head_cont ? ERR_STALE : ERR_TIMEOUT;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            gap_q      <= '0;
            stall_q    <= '0;
            cmd_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            gap_q      <= gap_d;
            stall_q    <= stall_d;
            cmd_q      <= cmd_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign CMD      = cmd_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with default parameters.
module tb_cmd_dispatch;

    logic       CLK = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [7:0] opcode;
    logic [7:0] BUSY;
    logic [7:0] CMD;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    cmd_dispatch u_dut (
        .CLK       (CLK),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .opcode    (opcode),
        .BUSY      (BUSY),
        .CMD       (CMD),
        .err       (err),
        .err_code  (err_code),
        .level     (level)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] op);
        pkt_valid = 1'b1;
        opcode    = op;
        tick();
        pkt_valid = 1'b0;
        opcode    = 8'h00;
    endtask

    logic [7:0] seq3 [6]  = '{8'h04, 8'h00, 8'h08, 8'h00, 8'h08, 8'h00};
    logic [7:0] seq4 [10] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};

    initial begin
        logic [7:0] cmd_or;
        logic       err_or;

        rst       = 1'b1;
        pkt_valid = 1'b0;
        opcode    = 8'h00;
        BUSY      = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_cmd", CMD, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'd0);
        check("rst_level", level, 3'd0);
        check("rst_ready", pkt_ready, 1'b1);

        // 1. basic issue
        push(8'd1);
        check("t1_level_after_push", level, 3'd1);
        check("t1_cmd_early", CMD, 8'h00);
        tick();
        check("t1_cmd", CMD, 8'h01);
        check("t1_level", level, 3'd0);
        tick();
        check("t1_cmd_one_cycle", CMD, 8'h00);

        // 2. held until engine frees
        BUSY = 8'h02;
        push(8'd2);
        cmd_or = 8'h00;
        err_or = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            cmd_or |= CMD;
            err_or |= err;
        end
        check("t2_no_cmd_while_busy", cmd_or, 8'h00);
        BUSY = 8'h00;
        tick();
        check("t2_cmd", CMD, 8'h02);
        err_or |= err;
        tick();
        check("t2_cmd_one_cycle", CMD, 8'h00);
        check("t2_no_err", err_or, 1'b0);

        // 3. session: BEGIN then two CONTINUEs gated by BUSY[2]
        push(8'd3);
        pkt_valid = 1'b1;
        opcode    = 8'd4;
        tick();
        check("t3_s0", CMD, seq3[0]);
        BUSY = 8'h04;
        push(8'd4);
        check("t3_s1", CMD, seq3[1]);
        for (int i = 2; i < 6; i++) begin
            tick();
            check($sformatf("t3_s%0d", i), CMD, seq3[i]);
        end
        BUSY = 8'h00;

        // 4. full and backpressure
        BUSY = 8'hFF;
        push(8'd1);
        push(8'd2);
        push(8'd3);
        check("t4_ready_at3", pkt_ready, 1'b1);
        push(8'd5);
        check("t4_ready_full", pkt_ready, 1'b0);
        check("t4_level_full", level, 3'd4);
        push(8'd7);
        check("t4_level_refused", level, 3'd4);
        BUSY = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t4_drain%0d", i), CMD, seq4[i]);
        end
        check("t4_level_empty", level, 3'd0);

        // 5a. illegal opcode
        push(8'h09);
        check("t5a_no_err_yet", err, 1'b0);
        tick();
        check("t5a_err", err, 1'b1);
        check("t5a_code", err_code, 2'd1);
        check("t5a_cmd", CMD, 8'h00);
        check("t5a_level", level, 3'd0);
        tick();
        check("t5a_err_pulse", err, 1'b0);
        check("t5a_code_held", err_code, 2'd1);

        // 5b. stale CONTINUE times out after 255 stalled cycles
        BUSY = 8'h00;
        push(8'd4);
        err_or = 1'b0;
        cmd_or = 8'h00;
        for (int i = 0; i < 254; i++) begin
            tick();
            err_or |= err;
            cmd_or |= CMD;
        end
        check("t5b_no_early_err", err_or, 1'b0);
        check("t5b_no_cmd", cmd_or, 8'h00);
        check("t5b_level_waiting", level, 3'd1);
        tick();
        check("t5b_err", err, 1'b1);
        check("t5b_code", err_code, 2'd3);
        check("t5b_cmd", CMD, 8'h00);
        check("t5b_level", level, 3'd0);

        // 6. reset discards queued entries
        BUSY = 8'hFF;
        push(8'd1);
        push(8'd2);
        push(8'd3);
        check("t6_level_pre", level, 3'd3);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        BUSY = 8'h00;
        check("t6_level", level, 3'd0);
        check("t6_cmd", CMD, 8'h00);
        check("t6_ready", pkt_ready, 1'b1);
        check("t6_code", err_code, 2'd0);
        cmd_or = 8'h00;
        for (int i = 0; i < 6; i++) begin
            tick();
            cmd_or |= CMD;
        end
        check("t6_no_strobe", cmd_or, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
